// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the M-extension execute unit: funct3 encodings, FSM states,
// and the legal multiplier depth range.
package ex_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam int MUL_STAGES_MIN = 1;
    localparam int MUL_STAGES_MAX = 4;
    localparam int MUL_CNT_W      = $clog2(MUL_STAGES_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_SIGN,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle; XLEN iterations after start.
// done is high during the final iteration; quotient/remainder are valid the cycle after.
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [XLEN:0]   shifted, trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        shifted = {rem_q, quo_q[XLEN-1]};
        // The partial remainder stays below the divisor, so bit XLEN of trial is a pure borrow.
        trial   = shifted - {1'b0, dvs_q};
        if (flush) begin
            busy_d = 1'b0;
        end else if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(XLEN);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
            rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M execute unit: MUL_STAGES-deep multiplier; restoring divider only when
// EX_MULDIV_DIV_EN is defined (otherwise divides raise illegal_op and are not accepted).
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rst_pipe,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_adr,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_adr_out,
    output logic            illegal_op
);
    localparam int STAGES = (MUL_STAGES < MUL_STAGES_MIN) ? MUL_STAGES_MIN :
                            (MUL_STAGES > MUL_STAGES_MAX) ? MUL_STAGES_MAX : MUL_STAGES;
    localparam int PW = 2 * XLEN + 2;
    localparam int RW = 2 * XLEN;

    state_e                 state_q, state_d;
    logic [2:0]             f3_q, f3_d;
    logic [4:0]             rd_q, rd_d, rdo_q, rdo_d;
    logic [MUL_CNT_W-1:0]   mcnt_q, mcnt_d;
    logic [XLEN-1:0]        res_q, res_d;
    logic                   done_q, done_d;
    logic                   flush, idle, is_div_req, accept;

    assign flush      = kill | rst_pipe;
    assign idle       = (state_q == ST_IDLE);
    assign is_div_req = funct3[2];

`ifdef EX_MULDIV_DIV_EN
    assign accept     = req_valid & idle & ~flush;
    assign illegal_op = 1'b0;
`else
    assign accept     = req_valid & idle & ~flush & ~is_div_req;
    assign illegal_op = req_valid & idle & ~flush & is_div_req;
`endif
    assign busy = ~idle | accept;

    // The first product stage registers straight from the forwarded operands in the accept cycle.
    logic            a_sgn, b_sgn;
    logic [PW-1:0]   a_ext, b_ext;
    logic [RW-1:0]   prod;
    logic [RW-1:0]   prod_q [STAGES];
    logic [RW-1:0]   prod_d [STAGES];

    assign a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    assign b_sgn = (funct3 == F3_MULH);
    assign a_ext = {{(XLEN+2){a_sgn & rs1[XLEN-1]}}, rs1};
    assign b_ext = {{(XLEN+2){b_sgn & rs2[XLEN-1]}}, rs2};
    assign prod  = RW'(a_ext * b_ext);

    always_comb begin
        prod_d[0] = prod;
        for (int i = 1; i < STAGES; i++) prod_d[i] = prod_q[i-1];
    end

`ifdef EX_MULDIV_DIV_EN
    logic            div_sgn, a_neg, b_neg, ovf, div_fix;
    logic [XLEN-1:0] a_mag, b_mag, quo, rem, a_q, a_d;
    logic            div0_q, div0_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic            core_start, core_busy, core_done;

    assign div_sgn    = ~funct3[0];
    assign a_neg      = div_sgn & rs1[XLEN-1];
    assign b_neg      = div_sgn & rs2[XLEN-1];
    assign a_mag      = a_neg ? -rs1 : rs1;
    assign b_mag      = b_neg ? -rs2 : rs2;
    assign ovf        = div_sgn & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
    assign div_fix    = (rs2 == '0) | ovf;
    assign core_start = accept & is_div_req & ~div_fix;

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .start     (core_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (core_busy),
        .done      (core_done),
        .quotient  (quo),
        .remainder (rem)
    );
`endif

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        mcnt_d  = mcnt_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        done_d  = 1'b0;
`ifdef EX_MULDIV_DIV_EN
        a_d     = a_q;
        div0_d  = div0_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        f3_d   = funct3;
                        rd_d   = rd_adr;
                        mcnt_d = MUL_CNT_W'(STAGES - 1);
                        if (!is_div_req) begin
                            state_d = ST_MUL;
                        end
`ifdef EX_MULDIV_DIV_EN
                        else begin
                            state_d = div_fix ? ST_FIX : ST_DIV;
                            a_d     = rs1;
                            div0_d  = (rs2 == '0);
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                        end
`endif
                    end
                end
                ST_MUL: begin
                    if (mcnt_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        rdo_d   = rd_q;
                        res_d   = (f3_q == F3_MUL) ? prod_q[STAGES-1][XLEN-1:0]
                                                   : prod_q[STAGES-1][RW-1:XLEN];
                    end else begin
                        mcnt_d = mcnt_q - MUL_CNT_W'(1);
                    end
                end
`ifdef EX_MULDIV_DIV_EN
                ST_DIV: begin
                    if (core_done)      state_d = ST_SIGN;
                    else if (!core_busy) state_d = ST_IDLE;
                end
                ST_SIGN: begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rdo_d   = rd_q;
                    res_d   = f3_q[1] ? (rneg_q ? -rem : rem) : (qneg_q ? -quo : quo);
                end
                ST_FIX: begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rdo_d   = rd_q;
                    if (f3_q[1]) res_d = div0_q ? a_q : '0;
                    else         res_d = div0_q ? '1  : a_q;
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            f3_q    <= '0;
            rd_q    <= '0;
            mcnt_q  <= '0;
            res_q   <= '0;
            rdo_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < STAGES; i++) prod_q[i] <= '0;
`ifdef EX_MULDIV_DIV_EN
            a_q     <= '0;
            div0_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            mcnt_q  <= mcnt_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
            done_q  <= done_d;
            for (int i = 0; i < STAGES; i++) prod_q[i] <= prod_d[i];
`ifdef EX_MULDIV_DIV_EN
            a_q     <= a_d;
            div0_q  <= div0_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign done       = done_q;
    assign result     = res_q;
    assign rd_adr_out = rdo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit (XLEN=32, MUL_STAGES=2): directed cases plus random ops
// checked against an arithmetic reference model; divide cases follow EX_MULDIV_DIV_EN.
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, rst_pipe, req_valid, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_adr;
    logic        busy, done, illegal_op;
    logic [31:0] result;
    logic [4:0]  rd_adr_out;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_res = '0;
    int          ndone;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_pipe   (rst_pipe),
        .req_valid  (req_valid),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd_adr     (rd_adr),
        .kill       (kill),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .rd_adr_out (rd_adr_out),
        .illegal_op (illegal_op)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        ia = a; ib = b; sa = ia; sb = ib; ub = {32'd0, b};
        ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
        case (f3)
            F3_MUL:    r = a * b;
            F3_MULH:   begin p = sa * sb; r = p[63:32]; end
            F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
            F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            F3_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : ia / ib;
            F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    r = (b == 0) ? a : ovf ? 32'd0 : ia % ib;
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return STAGES + 1;
        if (b == 0 || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF)) return 2;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MINV;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge: issues the request this cycle and follows it to done.
    task automatic run_body(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [4:0]  rd, rdo;
        logic [31:0] res;
        logic        bsy, ill;
        int          lat;
        rd = 5'($urandom_range(1, 31));
        req_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_adr = rd;
        #1;
        bsy = busy; ill = illegal_op;
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; res = '0; rdo = '0;
        for (int k = 1; k <= 80; k++) begin
            if (done) begin
                lat = k; res = result; rdo = rd_adr_out;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_busy_acc"}, 64'(bsy), 64'd1);
        chk({tag, "_no_illegal"}, 64'(ill), 64'd0);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, 64'(res), 64'(exp_res));
        chk({tag, "_rd"}, 64'(rdo), 64'(rd));
        last_res = exp_res;
    endtask

    task automatic run_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        @(negedge clk);
        run_body(tag, f3, a, b, exp_res, exp_lat);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        rst_n = 1'b0; rst_pipe = 1'b0; req_valid = 1'b0; kill = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0; rd_adr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_illegal", 64'(illegal_op), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_rd", 64'(rd_adr_out), 64'd0);
        rst_n = 1'b1;

        run_check("mulh_min", F3_MULH, MINV, MINV, 32'h4000_0000, STAGES + 1);
        @(negedge clk);
        chk("done_pulse_width", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("result_held", 64'(result), 64'h4000_0000);
        run_check("mulhsu_ones", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, STAGES + 1);
        run_check("mulhu_ones", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, STAGES + 1);
        run_check("mul_ones", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, STAGES + 1);

`ifdef EX_MULDIV_DIV_EN
        run_check("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, XLEN + 2);
        run_check("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, XLEN + 2);
        run_check("divu_by0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_check("rem_by0", F3_REM, 32'd5, 32'd0, 32'd5, 2);
        run_check("div_ovf", F3_DIV, MINV, 32'hFFFF_FFFF, MINV, 2);
        run_check("rem_ovf", F3_REM, MINV, 32'hFFFF_FFFF, 32'd0, 2);

        // Divide purged by kill in cycle 10; a multiply is issued in cycle 11.
        @(negedge clk);
        req_valid = 1'b1; funct3 = F3_DIV; rs1 = 32'd100; rs2 = 32'd3; rd_adr = 5'd9;
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 10) kill = 1'b1;
            if (done) ndone++;
        end
        @(negedge clk);
        kill = 1'b0;
        if (done) ndone++;
        chk("kill_no_done", 64'(ndone), 64'd0);
        chk("kill_idle", 64'(busy), 64'd0);
        chk("kill_result_held", 64'(result), 64'(last_res));
        run_body("mul_after_kill", F3_MUL, 32'd1234, 32'd5678, 32'd7006652, STAGES + 1);
`else
        @(negedge clk);
        req_valid = 1'b1; funct3 = F3_DIVU; rs1 = 32'd5; rs2 = 32'd0; rd_adr = 5'd3;
        #1;
        chk("illegal_pulse", 64'(illegal_op), 64'd1);
        chk("illegal_not_busy", 64'(busy), 64'd0);
        run_check("mul_after_illegal", F3_MUL, 32'd6, 32'd7, 32'd42, STAGES + 1);
`endif

        // Multiply flushed by rst_pipe in cycle 1.
        @(negedge clk);
        req_valid = 1'b1; funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd4; rd_adr = 5'd2;
        @(negedge clk);
        req_valid = 1'b0; rst_pipe = 1'b1;
        @(negedge clk);
        rst_pipe = 1'b0;
        chk("rst_pipe_idle", 64'(busy), 64'd0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("rst_pipe_no_done", 64'(ndone), 64'd0);
        chk("rst_pipe_result_held", 64'(result), 64'(last_res));

        for (int i = 0; i < 40; i++) begin
`ifdef EX_MULDIV_DIV_EN
            f3 = 3'($urandom_range(0, 7));
`else
            f3 = 3'($urandom_range(0, 3));
`endif
            a = pick();
            b = pick();
            run_check($sformatf("rand%0d_f%0d", i, f3), f3, a, b, model(f3, a, b), model_lat(f3, a, b));
        end

        // Asynchronous reset in the middle of a multiply, between clock edges.
        @(negedge clk);
        req_valid = 1'b1; funct3 = F3_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'd2; rd_adr = 5'd17;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_rd", 64'(rd_adr_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("mul_after_arst", F3_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, STAGES + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised RV32M/RV64M multiply/divide execution unit, placed beside the integer ALU in the execute stage. It accepts one M-extension operation at a time and computes multiplies in a configurable-depth pipeline and divides with a 1-bit-per-cycle restoring core. While an operation is in flight it holds the pipeline through `busy`. It returns the result with its destination register in a single-cycle `done` pulse.

## Interface
Parameters:
- `XLEN`, 32 — operand/result width (32 or 64).
- `MUL_STAGES`, 2 — multiplier register stages, 1..4.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `rst_pipe` in 1 — synchronous pipeline flush; same effect as `kill`.
- `req_valid` in 1 — operation request, qualified by `~busy`.
- `funct3` in 3 — 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, `rs2` in XLEN — forwarded operands, sampled at accept.
- `rd_adr` in 5 — destination register, sampled at accept.
- `kill` in 1 — jump purge; aborts the in-flight operation.
- `busy` out 1 — high from the accept cycle until `done`; the pipeline stalls on it.
- `done` out 1 — one-cycle result-valid pulse.
- `result` out XLEN — result; holds its value until the next `done`.
- `rd_adr_out` out 5 — destination register of `result`.
- `illegal_op` out 1 — one-cycle pulse when a divide is requested with the divider compiled out.

## Operation
- Accept: `req_valid & ~busy & ~kill`. In the accept cycle, latch the operands, `funct3` and `rd_adr`.
  - `busy` is combinationally high in the accept cycle and stays high until the `done` cycle inclusive.
- States:
  - IDLE → MUL when `funct3[2]=0`.
  - IDLE → DIV for a normal divide.
  - IDLE → FIX for a special-case divide.
  - MUL → DONE after `MUL_STAGES` cycles.
  - DIV → SIGN after XLEN iterations.
  - SIGN → DONE.
  - FIX → DONE.
  - DONE → IDLE.
- MUL: sign-extend or zero-extend to 2·XLEN+2 bits according to `funct3`, then take the full product.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- DIV: restoring division on operand magnitudes. SIGN negates the quotient when the operand signs differ, and negates the remainder when the dividend is negative. Signed ops only.
- FIX (special cases, no iteration):
  - Divide by zero: quotient = all-ones, remainder = `rs1`.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = `rs1`, remainder = 0.
- `kill` or `rst_pipe` in any non-IDLE state: return to IDLE next cycle, no `done`, `result` unchanged.
  - `kill` in the accept cycle blocks the accept.
- No new request is accepted in the `done` cycle; the earliest next accept is the following cycle.

## Timing
Latencies are counted from the accept cycle (cycle 0):
- MUL: `done` in cycle `MUL_STAGES`+1.
- DIV normal: `done` in cycle XLEN+2.
- DIV special case: `done` in cycle 2.

Reset values:
- `busy`, `done`, `illegal_op` = 0.
- `result` = 0.
- `rd_adr_out` = 0.
- State = IDLE.
- Reset mid-operation returns the unit to IDLE immediately; an asynchronous reset needs no clock.

## Configuration
- `EX_MULDIV_DIV_EN` defined: the divider is built and funct3 4..7 execute as described.
- Undefined: the divider, DIV, SIGN and FIX are removed. A divide request raises `illegal_op` in the accept cycle, the request is not accepted (`busy` stays 0), and the execute stage routes it to the illegal-instruction trap.

## Structure
- Package `ex_muldiv_pkg` holds:
  - the `funct3` localparams (`F3_MUL` … `F3_REMU`);
  - the state enum;
  - the `MUL_STAGES` legal-range constants.
- Sub-module `muldiv_div_core` contains the iterative restoring divider: start/busy/done, magnitude operands, quotient/remainder outputs. It exists only under `EX_MULDIV_DIV_EN`.
- The multiplier pipeline and sign handling stay in the top module.

## Test plan
Unless stated otherwise: `XLEN`=32, `MUL_STAGES`=2, `EX_MULDIV_DIV_EN` defined.
- MULH 0x80000000 × 0x80000000 → `done` in cycle 3; `result`=0x40000000, `rd_adr_out` = sampled `rd_adr`.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIV −7 / 2 → `done` in cycle 34, `result` 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF.
- DIVU 5/0 → `done` in cycle 2, `result` 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000 / −1 → 0x80000000. REM 0x80000000 / −1 → 0.
- DIV started, `kill` in cycle 10 → IDLE in cycle 11, no `done`; a new MUL accepted in cycle 11 completes normally.
- Divider compiled out: DIVU request → `illegal_op` pulse, `busy`=0, no `done`. A MUL request in the next cycle still completes.
